// File: rtl/mul_ctrl_pkg.sv
// Shared types for the multiplier-sharing controller: operation codes, FSM states,
// the request bundle and the operand-extension rules for the DATA_WIDTH+1 signed multiplier.
package mul_ctrl_pkg;

  // Request bundle operands are sized for the widest supported DATA_WIDTH.
  localparam int unsigned MAX_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } ctrl_state_t;

  typedef struct packed {
    mul_op_t                   op;
    logic [MAX_DATA_WIDTH-1:0] a;
    logic [MAX_DATA_WIDTH-1:0] b;
  } mul_req_t;

  function automatic logic ext_bit_a(input mul_op_t op, input logic sign);
    return (op == MULHU) ? 1'b0 : sign;
  endfunction

  function automatic logic ext_bit_b(input mul_op_t op, input logic sign);
    return (op == MUL || op == MULH) ? sign : 1'b0;
  endfunction

endpackage

// File: rtl/mul_share_controller.sv
// Two-port front end that time-shares one external signed (DATA_WIDTH+1)-bit multiplier.
// Optional MUL_ZERO_SKIP_EN answers zero-operand requests directly without the multiplier.
module mul_share_controller
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [1:0]                      req_valid_i,
  input  logic [1:0][1:0]                 req_op_i,
  input  logic [1:0][DATA_WIDTH-1:0]      req_operand_A_i,
  input  logic [1:0][DATA_WIDTH-1:0]      req_operand_B_i,
  output logic [1:0]                      req_ready_o,
  output logic                            resp_valid_o,
  output logic                            resp_port_o,
  output logic [DATA_WIDTH-1:0]           resp_data_o,
  input  logic                            resp_ready_i,
  output logic [DATA_WIDTH:0]             mul_operand_A_o,
  output logic [DATA_WIDTH:0]             mul_operand_B_o,
  output logic                            mul_valid_entry_o,
  input  logic [2*(DATA_WIDTH+1)-1:0]     mul_result_i,
  input  logic                            mul_data_valid_i,
  input  logic                            mul_idle_i
);

  ctrl_state_t             state_reg;
  logic                    rr_ptr_reg;
  logic                    port_reg;
  mul_op_t                 op_reg;
  logic [DATA_WIDTH:0]     mul_a_reg;
  logic [DATA_WIDTH:0]     mul_b_reg;
  logic [DATA_WIDTH-1:0]   result_reg;

  logic                    grant_any;
  logic                    grant_port;
  mul_req_t                grant_req;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic                    unused_req_pad;
  logic                    unused_product_top;

  // Contention goes to the round-robin pointer; a lone requester always wins.
  always_comb begin
    grant_any    = |req_valid_i;
    grant_port   = (req_valid_i == 2'b11) ? rr_ptr_reg : ~req_valid_i[0];
    grant_req.op = mul_op_t'(req_op_i[grant_port]);
    grant_req.a  = MAX_DATA_WIDTH'(req_operand_A_i[grant_port]);
    grant_req.b  = MAX_DATA_WIDTH'(req_operand_B_i[grant_port]);
    op_a         = DATA_WIDTH'(grant_req.a);
    op_b         = DATA_WIDTH'(grant_req.b);
  end

  // Padding bits of the bundle and the top product bits carry no information.
  assign unused_req_pad     = ^{grant_req.a, grant_req.b};
  assign unused_product_top = ^mul_result_i;

`ifdef MUL_ZERO_SKIP_EN
  logic zero_skip;
  assign zero_skip = (op_a == '0) || (op_b == '0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 1'b0;
      port_reg   <= 1'b0;
      op_reg     <= MUL;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            port_reg  <= grant_port;
            op_reg    <= grant_req.op;
            mul_a_reg <= {ext_bit_a(grant_req.op, op_a[DATA_WIDTH-1]), op_a};
            mul_b_reg <= {ext_bit_b(grant_req.op, op_b[DATA_WIDTH-1]), op_b};
`ifdef MUL_ZERO_SKIP_EN
            if (zero_skip) begin
              result_reg <= '0;
              state_reg  <= RESPOND;
            end else begin
              state_reg  <= ISSUE;
            end
`else
            state_reg <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          if (mul_idle_i) state_reg <= WAIT;
        end
        WAIT: begin
          if (mul_data_valid_i) begin
            result_reg <= (op_reg == MUL) ? mul_result_i[DATA_WIDTH-1:0]
                                          : mul_result_i[2*DATA_WIDTH-1:DATA_WIDTH];
            state_reg  <= RESPOND;
          end
        end
        RESPOND: begin
          if (resp_ready_i) begin
            rr_ptr_reg <= ~port_reg;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready_o       = (!rst_i && state_reg == IDLE && grant_any)
                             ? (grant_port ? 2'b10 : 2'b01) : 2'b00;
  assign mul_valid_entry_o = !rst_i && state_reg == ISSUE && mul_idle_i;
  assign resp_valid_o      = !rst_i && state_reg == RESPOND;
  assign resp_port_o       = port_reg;
  assign resp_data_o       = result_reg;
  assign mul_operand_A_o   = mul_a_reg;
  assign mul_operand_B_o   = mul_b_reg;

endmodule

// File: tb/tb_mul_share_controller.sv
// Directed bench for mul_share_controller with a fixed-latency signed multiplier model.
// Zero-skip expectations follow MUL_ZERO_SKIP_EN.
module tb_mul_share_controller;

  localparam int DW  = 32;
  localparam int LAT = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0][1:0]      req_op;
  logic [1:0][DW-1:0]   req_a;
  logic [1:0][DW-1:0]   req_b;
  logic [1:0]           req_ready;
  logic                 resp_valid;
  logic                 resp_port;
  logic [DW-1:0]        resp_data;
  logic                 resp_ready;
  logic [DW:0]          mul_a;
  logic [DW:0]          mul_b;
  logic                 mul_entry;
  logic [2*(DW+1)-1:0]  mul_result;
  logic                 mul_dv;
  logic                 mul_idle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_share_controller #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_op_i(req_op),
    .req_operand_A_i(req_a), .req_operand_B_i(req_b),
    .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_port_o(resp_port), .resp_data_o(resp_data),
    .resp_ready_i(resp_ready),
    .mul_operand_A_o(mul_a), .mul_operand_B_o(mul_b),
    .mul_valid_entry_o(mul_entry),
    .mul_result_i(mul_result), .mul_data_valid_i(mul_dv), .mul_idle_i(mul_idle)
  );

  // Multiplier model: captures on the start pulse, answers LAT cycles later; not reset by rst.
  logic [2*(DW+1)-1:0] prod  = '0;
  logic                busy  = 1'b0;
  logic                dv_q  = 1'b0;
  int                  cnt   = 0;
  logic                stall = 1'b0;
  logic                stray = 1'b0;

  assign mul_idle   = !busy && !stall;
  assign mul_dv     = dv_q | stray;
  assign mul_result = prod;

  always @(posedge clk) begin
    dv_q <= 1'b0;
    if (mul_entry) begin
      busy <= 1'b1;
      cnt  <= LAT - 1;
      prod <= $signed({{(DW+1){mul_a[DW]}}, mul_a}) * $signed({{(DW+1){mul_b[DW]}}, mul_b});
    end else if (busy) begin
      if (cnt == 0) begin
        busy <= 1'b0;
        dv_q <= 1'b1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int p, input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid    = 2'b00;
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_a[p]     = a;
    req_b[p]     = b;
    #1;
    chk("grant_ready", 64'(req_ready), (p == 0) ? 64'd1 : 64'd2);
    tick();
    req_valid = 2'b00;
  endtask

  // Waits for the response, checks it, then accepts it.
  task automatic finish(input string tag, input logic exp_port, input logic [DW-1:0] exp_data,
                        input int n0, input int exp_lat);
    int n = n0;
    while (resp_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 60), 64'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_port"}, 64'(resp_port), 64'(exp_port));
    chk({tag, "_data"}, 64'(resp_data), 64'(exp_data));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_drop"}, 64'(resp_valid), 64'd0);
    $display("txn %s port=%0d data=0x%08h", tag, resp_port, resp_data);
  endtask

  task automatic op_test(input string tag, input int p, input logic [1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW:0] ema, input logic [DW:0] emb, input logic [DW-1:0] exp);
    send(p, op, a, b);
    chk({tag, "_entry"}, 64'(mul_entry), 64'd1);
    chk({tag, "_opa"}, 64'(mul_a), 64'(ema));
    chk({tag, "_opb"}, 64'(mul_b), 64'(emb));
    tick();
    chk({tag, "_entry_off"}, 64'(mul_entry), 64'd0);
    chk({tag, "_opa_hold"}, 64'(mul_a), 64'(ema));
    finish(tag, p[0], exp, 1, 2 + LAT);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_op     = '0;
    req_a      = {32'd5, 32'd6};
    req_b      = {32'd7, 32'd8};
    resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_entry", 64'(mul_entry), 64'd0);
    chk("rst_opa", 64'(mul_a), 64'd0);
    chk("rst_opb", 64'(mul_b), 64'd0);
    chk("rst_data", 64'(resp_data), 64'd0);
    chk("rst_port", 64'(resp_port), 64'd0);
    req_valid = 2'b00;
    rst       = 1'b0;
    tick();

    op_test("mul_neg",   0, 2'b00, 32'd7,        32'hFFFFFFFD, 33'h0_00000007, 33'h1_FFFFFFFD, 32'hFFFFFFEB);
    op_test("mulhu_max", 1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 32'hFFFFFFFE);
    op_test("mulhsu_m1", 0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1_FFFFFFFF, 33'h0_FFFFFFFF, 32'hFFFFFFFF);
    op_test("mulh_min",  1, 2'b01, 32'h80000000, 32'h80000000, 33'h1_80000000, 33'h1_80000000, 32'h40000000);

    // Round robin after reset: 0, then 1, then 0 again with both requesting throughout.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_op    = '0;
    req_a     = {32'd4, 32'd2};
    req_b     = {32'd5, 32'd3};
    req_valid = 2'b11;
    #1;
    chk("rr_first", 64'(req_ready), 64'd1);
    tick();
    chk("rr_busy_ready", 64'(req_ready), 64'd0);
    finish("rr_p0", 1'b0, 32'd6, 0, 2 + LAT);
    chk("rr_second", 64'(req_ready), 64'd2);
    tick();
    finish("rr_p1", 1'b1, 32'd20, 0, 2 + LAT);
    chk("rr_third", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    finish("rr_p0_again", 1'b0, 32'd6, 0, 2 + LAT);

    // Response back-pressure for 5 cycles while port 1 waits.
    send(0, 2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF);
    for (int i = 0; i < 60 && resp_valid !== 1'b1; i++) tick();
    req_valid = 2'b10;
    req_op[1] = 2'b00;
    req_a[1]  = 32'd2;
    req_b[1]  = 32'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_data", 64'(resp_data), 64'h3FFFFFFF);
      chk("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    $display("txn bp port=0 data=0x3fffffff accepted after hold");
    chk("bp_next_grant", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    finish("bp_p1", 1'b1, 32'd6, 0, 2 + LAT);

    // Multiplier busy: start must wait for idle.
    stall = 1'b1;
    send(0, 2'b00, 32'd5, 32'd6);
    for (int i = 0; i < 3; i++) begin
      chk("stall_entry", 64'(mul_entry), 64'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("stall_release_entry", 64'(mul_entry), 64'd1);
    finish("stall", 1'b0, 32'd30, 0, -1);

    // Stray product pulse in IDLE is ignored.
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_ignored", 64'(resp_valid), 64'd0);
    tick();
    chk("stray_ignored2", 64'(resp_valid), 64'd0);

    // Reset while waiting for the product abandons the operation.
    send(0, 2'b00, 32'd7, 32'hFFFFFFFD);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_resp", 64'(resp_valid), 64'd0);
    chk("wrst_opa", 64'(mul_a), 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (resp_valid === 1'b1) seen = 1'b1;
        tick();
      end
      chk("wrst_no_resp", 64'(seen), 64'd0);
    end
    op_test("after_rst", 1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 32'hFFFFFFFE);

`ifdef MUL_ZERO_SKIP_EN
    send(0, 2'b00, 32'd0, 32'h1234);
    chk("zskip_valid", 64'(resp_valid), 64'd1);
    chk("zskip_entry", 64'(mul_entry), 64'd0);
    finish("zskip", 1'b0, 32'd0, 0, 0);
`else
    op_test("zero_mul", 0, 2'b00, 32'd0, 32'h1234, 33'h0_00000000, 33'h0_00001234, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
